// File: rtl/scc_ctrl_defs_pkg.sv
// rtl/scc_ctrl_defs_pkg.sv - shared widths, bit counts and FSM encoding for the SCC config sequencer
package scc_ctrl_defs_pkg;

  localparam int SCC_ADDR_W    = 12;
  localparam int SCC_DATA_W    = 32;
  localparam int SCC_ADDR_BITS = 12;
  localparam int SCC_DATA_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_LOAD  = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } scc_state_t;

endpackage

// File: rtl/scc_bit_timer.sv
// rtl/scc_bit_timer.sv - CFGCLK slot generator: CLK_DIV cycles low then CLK_DIV cycles high per slot
module scc_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic enable,
  output logic cfgclk,
  output logic slot_start,
  output logic rise_strobe,
  output logic slot_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          phase;
  logic          div_last;

  assign div_last = (div_cnt == CW'(CLK_DIV - 1));

  // phase is the CFGCLK level; it flips each time the divider wraps
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (div_last) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign cfgclk      = phase;
  assign slot_start  = enable && !phase && (div_cnt == '0);
  assign rise_strobe = enable && phase && (div_cnt == '0);
  assign slot_end    = enable && phase && div_last;

endmodule

// File: rtl/scc_master_ctrl.sv
// rtl/scc_master_ctrl.sv - SCC serial configuration port sequencer (one 44-bit transaction at a time)
module scc_master_ctrl
  import scc_ctrl_defs_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = SCC_ADDR_W,
  parameter int DATA_W  = SCC_DATA_W
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              nCFGRST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WNR,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              CFGCLK,
  output logic              CFGWNR,
  output logic              CFGLOAD,
  output logic              CFGDATAIN,
  input  logic              CFGDATAOUT
);

  scc_state_t        state;
  logic [1:0]        cfg_sync;
  logic              cfg_ok;
  logic [5:0]        bit_cnt;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] cap_next;
  logic              active;
  logic              timer_en;
  logic              slot_start;
  logic              slot_end;
  logic              rise_strobe;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) cfg_sync <= 2'b00;
    else         cfg_sync <= {cfg_sync[0], nCFGRST};
  end

  assign cfg_ok    = cfg_sync[1];
  assign active    = (state == ST_ADDR) || (state == ST_WDATA) ||
                     (state == ST_LOAD) || (state == ST_RDATA);
  // Dropping enable with cfg_ok kills CFGCLK on the same edge the FSM aborts
  assign timer_en  = active && cfg_ok;
  assign REQ_READY = (state == ST_IDLE) && cfg_ok;

  scc_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .enable      (timer_en),
    .cfgclk      (CFGCLK),
    .slot_start  (slot_start),
    .rise_strobe (rise_strobe),
    .slot_end    (slot_end)
  );

  // Read bits arrive LSB first, so they enter at the top and walk down to bit 0
  always_comb begin
    cap_next = shreg;
    if (rise_strobe && (state == ST_RDATA)) cap_next = {CFGDATAOUT, shreg[DATA_W-1:1]};
  end

  // bit_cnt counts slots started in the current state; it is compared at slot_end
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      addr_sh   <= '0;
      shreg     <= '0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
      CFGWNR    <= 1'b0;
      CFGLOAD   <= 1'b0;
      CFGDATAIN <= 1'b0;
    end else begin
      RSP_VALID <= 1'b0;
      if (slot_start) bit_cnt <= bit_cnt + 6'd1;
      if (active && !cfg_ok) begin
        state     <= ST_DONE;
        RSP_VALID <= 1'b1;
        RSP_ERR   <= 1'b1;
        RSP_RDATA <= '0;
        CFGWNR    <= 1'b0;
        CFGLOAD   <= 1'b0;
        CFGDATAIN <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (REQ_VALID && REQ_READY) begin
              state     <= ST_ADDR;
              bit_cnt   <= '0;
              addr_sh   <= REQ_ADDR;
              shreg     <= REQ_WDATA;
              CFGWNR    <= REQ_WNR;
              CFGDATAIN <= REQ_ADDR[ADDR_W-1];
            end
          end
          ST_ADDR: begin
            if (slot_end) begin
              if (bit_cnt == 6'(ADDR_W)) begin
                bit_cnt <= '0;
                if (CFGWNR) begin
                  state     <= ST_WDATA;
                  CFGDATAIN <= shreg[DATA_W-1];
                end else begin
                  state     <= ST_LOAD;
                  CFGLOAD   <= 1'b1;
                  CFGDATAIN <= 1'b0;
                end
              end else begin
                addr_sh   <= addr_sh << 1;
                CFGDATAIN <= addr_sh[ADDR_W-2];
              end
            end
          end
          ST_WDATA: begin
            if (slot_end) begin
              if (bit_cnt == 6'(DATA_W)) begin
                state     <= ST_LOAD;
                bit_cnt   <= '0;
                CFGLOAD   <= 1'b1;
                CFGDATAIN <= 1'b0;
              end else begin
                shreg     <= shreg << 1;
                CFGDATAIN <= shreg[DATA_W-2];
              end
            end
          end
          ST_LOAD: begin
            if (slot_end) begin
              CFGLOAD <= 1'b0;
              bit_cnt <= '0;
              if (CFGWNR) begin
                state     <= ST_DONE;
                RSP_VALID <= 1'b1;
                RSP_ERR   <= 1'b0;
                RSP_RDATA <= '0;
                CFGWNR    <= 1'b0;
              end else begin
                state <= ST_RDATA;
              end
            end
          end
          ST_RDATA: begin
            shreg <= cap_next;
            if (slot_end && (bit_cnt == 6'(DATA_W))) begin
              state     <= ST_DONE;
              RSP_VALID <= 1'b1;
              RSP_ERR   <= 1'b0;
              RSP_RDATA <= cap_next;
              CFGWNR    <= 1'b0;
            end
          end
          ST_DONE: begin
            state     <= ST_IDLE;
            RSP_ERR   <= 1'b0;
            RSP_RDATA <= '0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scc_master_ctrl.sv
// tb/tb_scc_master_ctrl.sv - directed self-checking bench for scc_master_ctrl (CLK_DIV 4 and 1)
module tb_scc_master_ctrl;

  logic        clk = 1'b0;
  logic        nreset, ncfgrst, req_valid, req_wnr;
  logic        cfgdataout = 1'b0;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  bit          sel = 1'b0;

  logic [1:0]  ready_v, rsp_valid_v, err_v, cclk_v, cwnr_v, cload_v, cdin_v;
  logic [31:0] rdata_v [2];

  logic        m_ready, m_rsp_valid, m_err, m_cclk, m_cwnr, m_cload, m_cdin;
  logic [31:0] m_rdata;

  int          checks = 0;
  int          errors = 0;
  int          txn_id = 0;
  int          last_id = 0;
  int          rises = 0;
  int          wnr_bad = 0;
  logic [44:0] din_rec = '0;
  logic [44:0] load_rec = '0;
  logic        prev_clk = 1'b0;
  logic        exp_wnr = 1'b0;
  logic [31:0] rd_model = '0;

  logic [31:0] s_rdata;
  logic        s_err, s_wnr, s_clk;
  int          lat;

  always #5 clk = ~clk;

  assign m_ready     = ready_v[sel];
  assign m_rsp_valid = rsp_valid_v[sel];
  assign m_err       = err_v[sel];
  assign m_cclk      = cclk_v[sel];
  assign m_cwnr      = cwnr_v[sel];
  assign m_cload     = cload_v[sel];
  assign m_cdin      = cdin_v[sel];
  assign m_rdata     = rdata_v[sel];

  scc_master_ctrl #(.CLK_DIV(4)) u_div4 (
    .CLK(clk), .nRESET(nreset), .nCFGRST(ncfgrst),
    .REQ_VALID(req_valid & ~sel), .REQ_READY(ready_v[0]), .REQ_WNR(req_wnr),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid_v[0]), .RSP_RDATA(rdata_v[0]), .RSP_ERR(err_v[0]),
    .CFGCLK(cclk_v[0]), .CFGWNR(cwnr_v[0]), .CFGLOAD(cload_v[0]),
    .CFGDATAIN(cdin_v[0]), .CFGDATAOUT(cfgdataout)
  );

  scc_master_ctrl #(.CLK_DIV(1)) u_div1 (
    .CLK(clk), .nRESET(nreset), .nCFGRST(ncfgrst),
    .REQ_VALID(req_valid & sel), .REQ_READY(ready_v[1]), .REQ_WNR(req_wnr),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid_v[1]), .RSP_RDATA(rdata_v[1]), .RSP_ERR(err_v[1]),
    .CFGCLK(cclk_v[1]), .CFGWNR(cwnr_v[1]), .CFGLOAD(cload_v[1]),
    .CFGDATAIN(cdin_v[1]), .CFGDATAOUT(cfgdataout)
  );

  // SCC-side model: records CFGDATAIN/CFGLOAD at each CFGCLK rise, drives read bits LSB first
  always @(negedge clk) begin
    if (txn_id != last_id) begin
      last_id  = txn_id;
      rises    = 0;
      din_rec  = '0;
      load_rec = '0;
      wnr_bad  = 0;
    end
    if (m_cclk && !prev_clk) begin
      din_rec  = {din_rec[43:0], m_cdin};
      load_rec = {load_rec[43:0], m_cload};
      if (m_cwnr !== exp_wnr) wnr_bad++;
      cfgdataout = (rises >= 13 && rises < 45) ? rd_model[rises-13] : 1'b0;
      rises++;
    end
    prev_clk = m_cclk;
  end

  task automatic do_txn(input logic wnr, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] rm);
    int n;
    req_wnr = wnr; req_addr = a; req_wdata = d; rd_model = rm; exp_wnr = wnr;
    req_valid = 1'b1;
    n = 0;
    while (m_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    txn_id++;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    while (m_rsp_valid !== 1'b1 && lat < 3000) begin @(negedge clk); lat++; end
    s_rdata = m_rdata; s_err = m_err; s_wnr = m_cwnr; s_clk = m_cclk;
  endtask

  task automatic test_reset();
    checks++;
    if ({m_ready, m_rsp_valid, m_err, m_cclk, m_cwnr, m_cload, m_cdin} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outs got %b exp 0000000", {m_ready, m_rsp_valid, m_err, m_cclk, m_cwnr, m_cload, m_cdin});
    end
    checks++;
    if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", m_rdata); end
    nreset = 1'b1;
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_sync1 got %b exp 0", m_ready); end
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_sync2 got %b exp 1", m_ready); end
  endtask

  task automatic test_write(input int exp_lat, input logic [11:0] a, input logic [31:0] d);
    do_txn(1'b1, a, d, 32'h0);
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL wr_latency got %0d exp %0d", lat, exp_lat); end
    checks++;
    if (din_rec !== {a, d, 1'b0}) begin errors++; $display("FAIL wr_serial got %h exp %h", din_rec, {a, d, 1'b0}); end
    checks++;
    if (load_rec !== 45'h1) begin errors++; $display("FAIL wr_load got %h exp %h", load_rec, 45'h1); end
    checks++;
    if (rises != 45) begin errors++; $display("FAIL wr_rises got %0d exp 45", rises); end
    checks++;
    if ({s_err, s_rdata, s_wnr, s_clk, wnr_bad[7:0]} !== 43'h0) begin
      errors++;
      $display("FAIL wr_rsp got err %b rdata %h wnr %b clk %b wnr_bad %0d exp all 0", s_err, s_rdata, s_wnr, s_clk, wnr_bad);
    end
  endtask

  task automatic test_read(input int exp_lat, input logic [11:0] a, input logic [31:0] rm);
    do_txn(1'b0, a, 32'hFFFF_FFFF, rm);
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL rd_latency got %0d exp %0d", lat, exp_lat); end
    checks++;
    if (s_rdata !== rm) begin errors++; $display("FAIL rd_data got %h exp %h", s_rdata, rm); end
    checks++;
    if (din_rec !== {a, 33'h0}) begin errors++; $display("FAIL rd_serial got %h exp %h", din_rec, {a, 33'h0}); end
    checks++;
    if (load_rec !== 45'h1_0000_0000) begin errors++; $display("FAIL rd_load got %h exp %h", load_rec, 45'h1_0000_0000); end
    checks++;
    if (rises != 45) begin errors++; $display("FAIL rd_rises got %0d exp 45", rises); end
    checks++;
    if (s_err !== 1'b0 || wnr_bad != 0) begin errors++; $display("FAIL rd_err_wnr got err %b wnr_bad %0d exp 0 0", s_err, wnr_bad); end
  endtask

  task automatic test_back_to_back();
    int accepts, pulses, cyc, last, gap_bad, rdy_bad;
    req_wnr = 1'b1; req_addr = 12'h3C5; req_wdata = 32'h0F1E_2D3C; exp_wnr = 1'b1;
    txn_id++;
    req_valid = 1'b1;
    accepts = 0; pulses = 0; cyc = 0; last = -1; gap_bad = 0; rdy_bad = 0;
    while (cyc < 1500 && !(pulses == 3 && cyc > last + 400)) begin
      @(negedge clk); cyc++;
      if (m_rsp_valid === 1'b1) begin
        pulses++;
        if (m_ready !== 1'b0 || m_cclk !== 1'b0) rdy_bad++;
        if (last >= 0 && cyc - last != 362) gap_bad++;
        last = cyc;
      end
      if (m_ready === 1'b1 && req_valid) begin
        accepts++;
        if (accepts == 3) begin @(posedge clk); #1 req_valid = 1'b0; end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (pulses != 3 || accepts != 3) begin errors++; $display("FAIL b2b_count got pulses %0d accepts %0d exp 3 3", pulses, accepts); end
    checks++;
    if (gap_bad != 0) begin errors++; $display("FAIL b2b_gap got %0d bad gaps exp 0", gap_bad); end
    checks++;
    if (rdy_bad != 0) begin errors++; $display("FAIL b2b_done_ready_clk got %0d bad exp 0", rdy_bad); end
    checks++;
    if (rises != 135) begin errors++; $display("FAIL b2b_rises got %0d exp 135", rises); end
  endtask

  task automatic test_cfgrst_abort();
    int n;
    req_wnr = 1'b1; req_addr = 12'h0F0; req_wdata = 32'hDEAD_BEEF; exp_wnr = 1'b1;
    req_valid = 1'b1; n = 0;
    while (m_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    txn_id++;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (rises < 23 && n < 1000) begin @(negedge clk); n++; end
    ncfgrst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (m_cclk !== 1'b1 || m_rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_pre got clk %b rsp %b exp 1 0", m_cclk, m_rsp_valid); end
    @(negedge clk);
    checks++;
    if ({m_cclk, m_cload, m_cdin, m_cwnr} !== 4'b0) begin errors++; $display("FAIL abort_cfg_zero got %b exp 0000", {m_cclk, m_cload, m_cdin, m_cwnr}); end
    checks++;
    if (m_rsp_valid !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'h0) begin
      errors++; $display("FAIL abort_rsp got valid %b err %b rdata %h exp 1 1 0", m_rsp_valid, m_err, m_rdata);
    end
    n = 0;
    repeat (5) begin @(negedge clk); if (m_ready !== 1'b0) n++; end
    checks++;
    if (n != 0) begin errors++; $display("FAIL abort_ready_low got %0d high cycles exp 0", n); end
    ncfgrst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_sync1 got %b exp 0", m_ready); end
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_sync2 got %b exp 1", m_ready); end
  endtask

  task automatic test_nreset_mid();
    int n, pulses;
    req_wnr = 1'b0; req_addr = 12'h3AB; req_wdata = 32'h0; rd_model = 32'h1234_5678; exp_wnr = 1'b0;
    req_valid = 1'b1; n = 0;
    while (m_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    txn_id++;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (rises < 20 && n < 1000) begin @(negedge clk); n++; end
    nreset = 1'b0;
    #1;
    checks++;
    if ({m_ready, m_rsp_valid, m_err, m_cclk, m_cwnr, m_cload, m_cdin} !== 7'b0 || m_rdata !== 32'h0) begin
      errors++;
      $display("FAIL nreset_async got %b rdata %h exp 0000000 0", {m_ready, m_rsp_valid, m_err, m_cclk, m_cwnr, m_cload, m_cdin}, m_rdata);
    end
    pulses = 0;
    repeat (4) begin @(negedge clk); if (m_rsp_valid !== 1'b0) pulses++; end
    nreset = 1'b1;
    repeat (400) begin @(negedge clk); if (m_rsp_valid !== 1'b0) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL nreset_no_rsp got %0d pulses exp 0", pulses); end
    test_write(361, 12'h001, 32'h8000_0001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog no finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; ncfgrst = 1'b1; req_valid = 1'b0; req_wnr = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_write(361, 12'h123, 32'hDEAD_BEEF);
    test_read(361, 12'hCCC, 32'h0000_00A5);
    test_back_to_back();
    test_cfgrst_abort();
    test_nreset_mid();
    sel = 1'b1;
    @(negedge clk);
    test_write(91, 12'hA5A, 32'h1357_9BDF);
    test_read(91, 12'h5A5, 32'hC3A5_0F81);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
